control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Hardwired Moore sequencer for the one-bus datapath.
- Generates every datapath control strobe: fetch T0–T2, then per-opcode execute steps T3–T7, then back to fetch.
- Sits beside `datapath`. Reads the IR opcode and the CON flip-flop; drives the datapath's bus-select, register-enable, ALU-op and memory-strobe inputs.

Parameters:
OP_MSB, 31, bit position of opcode MSB in ir
OP_W, 5, opcode width

Ports:
clk  in  1  system clock, all state changes on posedge
clr  in  1  synchronous active-high reset
ir  in  32  IR contents from datapath; opcode = ir[OP_MSB -: OP_W]
con_ff  in  1  branch-condition flop output from datapath
stop  in  1  request halt at next instruction boundary
PCout, Zlowout, Zhighout, MDRout, Cout, BAout, Rout, HIout, LOout  out  1 each  bus drive selects
MARIn, PCIn, MDRIn, IRIn, YIn, ZIn, RIn, HiIn, LoIn, CONIn, IncPC  out  1 each  register/latch enables
Gra, Grb, Grc  out  1 each  register-field selects
read, write  out  1 each  memory strobes
add, subtract, multiply, divide, andSignal, orSignal  out  1 each  ALU op, one-hot or zero
run  out  1  high unless in HALT
state  out  4  current state code, for debug

Behaviour:
- **State codes:** RESET=0000, T0=0111, T1=1000, T2=1001, T3=1010, T4=1011, T5=1100, T6=1101, T7=1110, HALT=1111.
- **Output timing:** every state lasts exactly one clk. Outputs are a combinational decode of the state register plus opcode. No strobe is asserted in RESET or HALT.
- **Reset:** clr=1 at a posedge puts the state in RESET regardless of current state. That includes aborting mid-instruction; read and write are low from that edge.
- RESET→T0 on the first posedge with clr=0. run=1 everywhere except HALT.
- **Fetch (all opcodes):**
  - T0: PCout MARIn IncPC ZIn
  - T1: Zlowout PCIn read MDRIn
  - T2: MDRout IRIn
  - IR loads at the T2→T3 edge. ir is stable from T3 until the next T2.
- **Execute, by opcode:**
  - add 00011, sub 00100, and 01001, or 01010: T3 Grb Rout YIn; T4 Grc Rout op ZIn; T5 Zlowout Gra RIn.
  - addi 01011, andi 01100, ori 01101: T3 Grb Rout YIn; T4 Cout op ZIn; T5 Zlowout Gra RIn.
  - mul 01110, div 01111: T3 Gra Rout YIn; T4 Grb Rout op ZIn; T5 Zlowout LoIn; T6 Zhighout HiIn.
  - ldi 00001: T3 Grb BAout YIn; T4 Cout add ZIn; T5 Zlowout Gra RIn.
  - ld 00000: T3 Grb BAout YIn; T4 Cout add ZIn; T5 Zlowout MARIn; T6 read MDRIn; T7 MDRout Gra RIn.
  - st 00010: T3–T5 as ld; T6 Gra Rout MDRIn (read=0); T7 write.
  - brx 10010: T3 Gra Rout CONIn; T4 PCout YIn; T5 Cout add ZIn; T6 Zlowout PCIn only if con_ff=1, otherwise no strobes.
  - mfhi 10111: T3 HIout Gra RIn. mflo 11000: T3 LOout Gra RIn.
  - nop 11001 and any undefined opcode: T3 with no strobes.
  - halt 11010: T3→HALT.
- **Completion:** after an instruction's last step, go to T0, or to HALT if stop=1 at that edge.
- **HALT:** absorbing. Left only via clr.
- **ALU op lines:** asserted only in the ZIn step, one-hot. addi/ldi/ld/st/brx use add; andi uses andSignal; ori uses orSignal.
- **Step counts:**
  - ALU and immediate ops: T0 through T5.
  - ld, st: T0 through T7.
  - mul, div, brx: T0 through T6.
- **Invariants:** never assert read and write together. Never assert more than one bus-drive select in any state.

Test Plan:
- **Reset:** clr=1 for 2 clk, then 0 → state=0000 with all strobes 0; next clk state=0111 with PCout=MARIn=IncPC=ZIn=1.
- **addi:** ir=0x59800005 (addi, opcode 01011) → T3 Grb,Rout,YIn; T4 Cout,add,ZIn; T5 Zlowout,Gra,RIn; next state T0. Total 6 cycles after fetch start.
- **ld:** ir opcode 00000 → T6 read=1,MDRIn=1; T7 MDRout,Gra,RIn; write never 1. Likewise st: T7 write=1, read=0.
- **brx:** con_ff=1 → T6 PCIn=1,Zlowout=1. Repeat with con_ff=0 → T6 all strobes 0; both cases return to T0.
- **mul + stop:** mul with stop=1 → T5 LoIn, T6 HiIn, then state=1111 and run=0. Stays there for 10 clk. clr pulse → RESET, then T0.
- **Mid-op reset:** clr=1 during ld T6 → next posedge state=0000, read=0, MDRIn=0; fetch restarts at T0.

Source files
------------

// File: rtl/control_unit.sv
// control_unit: hardwired Moore sequencer for the one-bus datapath.
// Fetch T0-T2, per-opcode execute T3-T7, then back to fetch or HALT.
module control_unit #(
    parameter int OP_MSB = 31,
    parameter int OP_W   = 5
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        con_ff,
    input  logic        stop,
    output logic        PCout,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        MDRout,
    output logic        Cout,
    output logic        BAout,
    output logic        Rout,
    output logic        HIout,
    output logic        LOout,
    output logic        MARIn,
    output logic        PCIn,
    output logic        MDRIn,
    output logic        IRIn,
    output logic        YIn,
    output logic        ZIn,
    output logic        RIn,
    output logic        HiIn,
    output logic        LoIn,
    output logic        CONIn,
    output logic        IncPC,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        read,
    output logic        write,
    output logic        add,
    output logic        subtract,
    output logic        multiply,
    output logic        divide,
    output logic        andSignal,
    output logic        orSignal,
    output logic        run,
    output logic [3:0]  state
);
    localparam logic [3:0] S_RESET = 4'b0000, S_T0 = 4'b0111, S_T1 = 4'b1000, S_T2 = 4'b1001,
                           S_T3 = 4'b1010, S_T4 = 4'b1011, S_T5 = 4'b1100, S_T6 = 4'b1101,
                           S_T7 = 4'b1110, S_HALT = 4'b1111;

    localparam logic [OP_W-1:0] OP_LD = OP_W'(5'b00000), OP_LDI = OP_W'(5'b00001),
                                OP_ST = OP_W'(5'b00010), OP_ADD = OP_W'(5'b00011),
                                OP_SUB = OP_W'(5'b00100), OP_AND = OP_W'(5'b01001),
                                OP_OR = OP_W'(5'b01010), OP_ADDI = OP_W'(5'b01011),
                                OP_ANDI = OP_W'(5'b01100), OP_ORI = OP_W'(5'b01101),
                                OP_MUL = OP_W'(5'b01110), OP_DIV = OP_W'(5'b01111),
                                OP_BRX = OP_W'(5'b10010), OP_MFHI = OP_W'(5'b10111),
                                OP_MFLO = OP_W'(5'b11000), OP_HALT = OP_W'(5'b11010);

    logic [3:0]      r_state;
    logic [3:0]      w_next;
    logic [3:0]      w_end;
    logic [OP_W-1:0] w_op;
    logic w_alu3, w_imm, w_md, w_ldi, w_ld, w_st, w_brx, w_mfhi, w_mflo, w_halt, w_mem, w_zop;
    logic w_t0, w_t1, w_t2, w_t3, w_t4, w_t5, w_t6, w_t7;

    // Shift rather than slice so every ir bit is consumed.
    assign w_op   = OP_W'(ir >> (OP_MSB - OP_W + 1));
    assign w_alu3 = (w_op == OP_ADD) | (w_op == OP_SUB) | (w_op == OP_AND) | (w_op == OP_OR);
    assign w_imm  = (w_op == OP_ADDI) | (w_op == OP_ANDI) | (w_op == OP_ORI);
    assign w_md   = (w_op == OP_MUL) | (w_op == OP_DIV);
    assign w_ldi  = w_op == OP_LDI;
    assign w_ld   = w_op == OP_LD;
    assign w_st   = w_op == OP_ST;
    assign w_brx  = w_op == OP_BRX;
    assign w_mfhi = w_op == OP_MFHI;
    assign w_mflo = w_op == OP_MFLO;
    assign w_halt = w_op == OP_HALT;
    assign w_mem  = w_ld | w_st;
    assign w_end  = (w_alu3 | w_imm | w_ldi) ? S_T5 : w_mem ? S_T7 : (w_md | w_brx) ? S_T6 : S_T3;

    assign w_t0 = r_state == S_T0;
    assign w_t1 = r_state == S_T1;
    assign w_t2 = r_state == S_T2;
    assign w_t3 = r_state == S_T3;
    assign w_t4 = r_state == S_T4;
    assign w_t5 = r_state == S_T5;
    assign w_t6 = r_state == S_T6;
    assign w_t7 = r_state == S_T7;

    always_ff @(posedge clk) begin
        if (clr)
            r_state <= S_RESET;
        else
            r_state <= w_next;
    end

    // T0..T7 are consecutive codes, so stepping is an increment.
    always_comb begin
        w_next = r_state + 4'd1;
        if (r_state == S_HALT)
            w_next = S_HALT;
        else if (r_state < S_T0)
            w_next = S_T0;
        else if (w_t3 && w_halt)
            w_next = S_HALT;
        else if (r_state >= S_T3 && r_state == w_end)
            w_next = stop ? S_HALT : S_T0;
    end

    always_comb begin
        w_zop     = (w_t4 & (w_alu3 | w_imm | w_md | w_ldi | w_mem)) | (w_t5 & w_brx);
        PCout     = w_t0 | (w_t4 & w_brx);
        Zlowout   = w_t1 | (w_t5 & (w_alu3 | w_imm | w_ldi | w_md | w_mem)) | (w_t6 & w_brx & con_ff);
        Zhighout  = w_t6 & w_md;
        MDRout    = w_t2 | (w_t7 & w_ld);
        Cout      = (w_t4 & (w_imm | w_ldi | w_mem)) | (w_t5 & w_brx);
        BAout     = w_t3 & (w_ldi | w_mem);
        Rout      = (w_t3 & (w_alu3 | w_imm | w_md | w_brx)) | (w_t4 & (w_alu3 | w_md)) | (w_t6 & w_st);
        HIout     = w_t3 & w_mfhi;
        LOout     = w_t3 & w_mflo;
        MARIn     = w_t0 | (w_t5 & w_mem);
        PCIn      = w_t1 | (w_t6 & w_brx & con_ff);
        MDRIn     = w_t1 | (w_t6 & w_mem);
        IRIn      = w_t2;
        YIn       = (w_t3 & (w_alu3 | w_imm | w_md | w_ldi | w_mem)) | (w_t4 & w_brx);
        ZIn       = w_t0 | w_zop;
        RIn       = (w_t3 & (w_mfhi | w_mflo)) | (w_t5 & (w_alu3 | w_imm | w_ldi)) | (w_t7 & w_ld);
        HiIn      = w_t6 & w_md;
        LoIn      = w_t5 & w_md;
        CONIn     = w_t3 & w_brx;
        IncPC     = w_t0;
        Gra       = (w_t3 & (w_md | w_brx | w_mfhi | w_mflo)) | (w_t5 & (w_alu3 | w_imm | w_ldi))
                  | (w_t6 & w_st) | (w_t7 & w_ld);
        Grb       = (w_t3 & (w_alu3 | w_imm | w_ldi | w_mem)) | (w_t4 & w_md);
        Grc       = w_t4 & w_alu3;
        read      = w_t1 | (w_t6 & w_ld);
        write     = w_t7 & w_st;
        add       = w_zop & ((w_op == OP_ADD) | (w_op == OP_ADDI) | w_ldi | w_mem | w_brx);
        subtract  = w_zop & (w_op == OP_SUB);
        multiply  = w_zop & (w_op == OP_MUL);
        divide    = w_zop & (w_op == OP_DIV);
        andSignal = w_zop & ((w_op == OP_AND) | (w_op == OP_ANDI));
        orSignal  = w_zop & ((w_op == OP_OR) | (w_op == OP_ORI));
        run       = r_state != S_HALT;
        state     = r_state;
    end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: random + directed instruction streams against a step-table model of the sequencer.
module tb_control_unit;
    logic clk = 1'b0, clr = 1'b1, con_ff = 1'b0, stop = 1'b0;
    logic [31:0] ir = 32'd0;
    logic PCout, Zlowout, Zhighout, MDRout, Cout, BAout, Rout, HIout, LOout;
    logic MARIn, PCIn, MDRIn, IRIn, YIn, ZIn, RIn, HiIn, LoIn, CONIn, IncPC;
    logic Gra, Grb, Grc, read, write, add, subtract, multiply, divide, andSignal, orSignal, run;
    logic [3:0] state;
    logic [31:0] outs;
    int checks = 0, failures = 0;

    localparam int K_RST = 0, K_RUN = 1, K_HLT = 2;
    int m_kind = K_RST, m_step = 0;

    localparam logic [31:0] B_PCout = 32'd1 << 0, B_Zlow = 32'd1 << 1, B_Zhigh = 32'd1 << 2,
        B_MDRout = 32'd1 << 3, B_Cout = 32'd1 << 4, B_BAout = 32'd1 << 5, B_Rout = 32'd1 << 6,
        B_HIout = 32'd1 << 7, B_LOout = 32'd1 << 8, B_MARIn = 32'd1 << 9, B_PCIn = 32'd1 << 10,
        B_MDRIn = 32'd1 << 11, B_IRIn = 32'd1 << 12, B_YIn = 32'd1 << 13, B_ZIn = 32'd1 << 14,
        B_RIn = 32'd1 << 15, B_HiIn = 32'd1 << 16, B_LoIn = 32'd1 << 17, B_CONIn = 32'd1 << 18,
        B_IncPC = 32'd1 << 19, B_Gra = 32'd1 << 20, B_Grb = 32'd1 << 21, B_Grc = 32'd1 << 22,
        B_read = 32'd1 << 23, B_write = 32'd1 << 24, B_add = 32'd1 << 25, B_sub = 32'd1 << 26,
        B_mul = 32'd1 << 27, B_div = 32'd1 << 28, B_or = 32'd1 << 29, B_and = 32'd1 << 30,
        B_run = 32'd1 << 31;

    control_unit dut (
        .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff), .stop(stop),
        .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout), .Cout(Cout),
        .BAout(BAout), .Rout(Rout), .HIout(HIout), .LOout(LOout), .MARIn(MARIn), .PCIn(PCIn),
        .MDRIn(MDRIn), .IRIn(IRIn), .YIn(YIn), .ZIn(ZIn), .RIn(RIn), .HiIn(HiIn), .LoIn(LoIn),
        .CONIn(CONIn), .IncPC(IncPC), .Gra(Gra), .Grb(Grb), .Grc(Grc), .read(read), .write(write),
        .add(add), .subtract(subtract), .multiply(multiply), .divide(divide),
        .andSignal(andSignal), .orSignal(orSignal), .run(run), .state(state)
    );

    assign outs = {run, andSignal, orSignal, divide, multiply, subtract, add, write, read, Grc, Grb, Gra,
                   IncPC, CONIn, LoIn, HiIn, RIn, ZIn, YIn, IRIn, MDRIn, PCIn, MARIn,
                   LOout, HIout, Rout, BAout, Cout, MDRout, Zhighout, Zlowout, PCout};

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_op(input logic [4:0] op);
        case (op)
            5'b00011, 5'b01011: return B_add;
            5'b00100:           return B_sub;
            5'b01001, 5'b01100: return B_and;
            5'b01010, 5'b01101: return B_or;
            5'b01110:           return B_mul;
            5'b01111:           return B_div;
            default:            return 32'd0;
        endcase
    endfunction

    // Final execute step of each instruction, straight from the per-opcode step lists.
    function automatic int last_step(input logic [4:0] op);
        case (op)
            5'b00011, 5'b00100, 5'b01001, 5'b01010, 5'b01011, 5'b01100, 5'b01101, 5'b00001: return 5;
            5'b00000, 5'b00010: return 7;
            5'b01110, 5'b01111, 5'b10010: return 6;
            default: return 3;
        endcase
    endfunction

    function automatic logic [31:0] exec_mask(input logic [4:0] op, input int s, input logic c);
        case (op)
            5'b00011, 5'b00100, 5'b01001, 5'b01010:
                return s == 3 ? B_Grb | B_Rout | B_YIn : s == 4 ? B_Grc | B_Rout | alu_op(op) | B_ZIn :
                       s == 5 ? B_Zlow | B_Gra | B_RIn : 32'd0;
            5'b01011, 5'b01100, 5'b01101:
                return s == 3 ? B_Grb | B_Rout | B_YIn : s == 4 ? B_Cout | alu_op(op) | B_ZIn :
                       s == 5 ? B_Zlow | B_Gra | B_RIn : 32'd0;
            5'b01110, 5'b01111:
                return s == 3 ? B_Gra | B_Rout | B_YIn : s == 4 ? B_Grb | B_Rout | alu_op(op) | B_ZIn :
                       s == 5 ? B_Zlow | B_LoIn : s == 6 ? B_Zhigh | B_HiIn : 32'd0;
            5'b00001:
                return s == 3 ? B_Grb | B_BAout | B_YIn : s == 4 ? B_Cout | B_add | B_ZIn :
                       s == 5 ? B_Zlow | B_Gra | B_RIn : 32'd0;
            5'b00000:
                return s == 3 ? B_Grb | B_BAout | B_YIn : s == 4 ? B_Cout | B_add | B_ZIn :
                       s == 5 ? B_Zlow | B_MARIn : s == 6 ? B_read | B_MDRIn :
                       s == 7 ? B_MDRout | B_Gra | B_RIn : 32'd0;
            5'b00010:
                return s == 3 ? B_Grb | B_BAout | B_YIn : s == 4 ? B_Cout | B_add | B_ZIn :
                       s == 5 ? B_Zlow | B_MARIn : s == 6 ? B_Gra | B_Rout | B_MDRIn :
                       s == 7 ? B_write : 32'd0;
            5'b10010:
                return s == 3 ? B_Gra | B_Rout | B_CONIn : s == 4 ? B_PCout | B_YIn :
                       s == 5 ? B_Cout | B_add | B_ZIn : (s == 6 && c) ? B_Zlow | B_PCIn : 32'd0;
            5'b10111: return s == 3 ? B_HIout | B_Gra | B_RIn : 32'd0;
            5'b11000: return s == 3 ? B_LOout | B_Gra | B_RIn : 32'd0;
            default:  return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] exp_outs(input logic [4:0] op, input logic c);
        if (m_kind == K_HLT) return 32'd0;
        if (m_kind == K_RST) return B_run;
        case (m_step)
            0: return B_run | B_PCout | B_MARIn | B_IncPC | B_ZIn;
            1: return B_run | B_Zlow | B_PCIn | B_read | B_MDRIn;
            2: return B_run | B_MDRout | B_IRIn;
            default: return B_run | exec_mask(op, m_step, c);
        endcase
    endfunction

    function automatic logic [3:0] exp_state();
        return m_kind == K_RST ? 4'b0000 : m_kind == K_HLT ? 4'b1111 : 4'(7 + m_step);
    endfunction

    task automatic tick();
        logic [31:0] iv;
        logic [4:0] op;
        logic [31:0] eo;
        @(posedge clk);
        iv = ir;
        op = iv[31:27];
        if (clr) m_kind = K_RST;
        else if (m_kind == K_RST) begin m_kind = K_RUN; m_step = 0; end
        else if (m_kind == K_RUN) begin
            if (m_step == 3 && op == 5'b11010) m_kind = K_HLT;
            else if (m_step >= 3 && m_step == last_step(op)) begin
                if (stop) m_kind = K_HLT; else m_step = 0;
            end else m_step++;
        end
        #1;
        eo = exp_outs(op, con_ff);
        checks++;
        assert (state === exp_state()) else begin
            failures++;
            $error("FAIL state got=%b exp=%b", state, exp_state());
        end
        checks++;
        assert (outs === eo) else begin
            failures++;
            $error("FAIL strobes st=%b op=%b got=%h exp=%h", state, op, outs, eo);
        end
        checks++;
        assert (!(read && write) && $countones(outs[8:0]) <= 1) else begin
            failures++;
            $error("FAIL invariant rd=%b wr=%b bus=%b", read, write, outs[8:0]);
        end
    endtask

    // Runs one instruction from T0; stop_end drives stop at its final step, abort_at pulses clr there.
    task automatic do_instr(input logic [31:0] iv, input logic c, input logic stop_end, input int abort_at);
        int n = 0;
        logic [4:0] op = iv[31:27];
        do begin
            con_ff = (m_step == 6) ? c : 1'($urandom);
            stop = (m_step >= 3 && m_step == last_step(op)) ? stop_end : 1'($urandom);
            clr = (m_step == abort_at);
            if (m_step == 2) ir = iv;
            tick();
            clr = 1'b0;
            n++;
        end while (m_kind == K_RUN && m_step != 0 && n < 20);
    endtask

    task automatic recover(input int halt_cycles);
        if (m_kind == K_HLT) begin
            repeat (halt_cycles) begin stop = 1'($urandom); tick(); end
            clr = 1'b1;
            tick();
            clr = 1'b0;
        end
        if (m_kind == K_RST) tick();
    endtask

    initial begin
        logic [4:0] ops [16] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b01001, 5'b01010,
                                 5'b01011, 5'b01100, 5'b01101, 5'b01110, 5'b01111, 5'b10010, 5'b10111,
                                 5'b11000, 5'b11001};
        logic [31:0] r;
        logic [4:0] op;
        clr = 1'b1;
        tick();
        tick();
        clr = 1'b0;
        tick();
        do_instr(32'h59800005, 1'b0, 1'b0, -1);
        do_instr({5'b00000, 27'h0123456}, 1'b0, 1'b0, -1);
        do_instr({5'b00010, 27'h0654321}, 1'b1, 1'b0, -1);
        do_instr({5'b10010, 27'h0000abc}, 1'b1, 1'b0, -1);
        do_instr({5'b10010, 27'h0000abc}, 1'b0, 1'b0, -1);
        do_instr({5'b01110, 27'h1111111}, 1'b0, 1'b1, -1);
        recover(10);
        do_instr({5'b00000, 27'h0000007}, 1'b0, 1'b0, 6);
        recover(0);
        do_instr({5'b11010, 27'h0}, 1'b0, 1'b0, -1);
        recover(4);
        for (int i = 0; i < 300; i++) begin
            r = $urandom;
            op = ($urandom_range(0, 3) == 0) ? r[4:0] : ops[$urandom_range(0, 15)];
            r = $urandom;
            do_instr({op, r[26:0]}, 1'($urandom), $urandom_range(0, 9) == 0,
                     ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 7)) : -1);
            recover(int'($urandom_range(1, 5)));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
